expr_result_serializer: RTL and testbench
=========================================

EXPR_RESULT_SERIALIZER -- requirements
Module: expr_result_serializer

Interface
REQ-001 Parameter WIDTH, default 32, sets the data width of every result word.
REQ-002 Parameter EMIT_CHECKSUM, default 1; when 1, a seventh XOR-checksum word is appended to each bundle.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream bundle (res1..res6) valid.
REQ-006 in_ready  output  1  block accepts a bundle this cycle.
REQ-007 res1..res6  input  WIDTH each  six expression results from the upstream combinational evaluator (its output1..output6).
REQ-008 out_valid  output  1  out_data holds a valid word.
REQ-009 out_ready  input  1  downstream accepts a word.
REQ-010 out_data  output  WIDTH  current serialized word.
REQ-011 out_idx  output  3  index of the current word: 0..5 for results, 6 for checksum.
REQ-012 out_last  output  1  current word is the final word of its bundle.
REQ-013 busy  output  1  high while in state SEND.
REQ-014 bundle_cnt  output  16  count of fully emitted bundles.

Function
REQ-015 Two states: IDLE and SEND.
REQ-016 In IDLE: in_ready=1, out_valid=0, out_last=0; an in_valid&&in_ready handshake captures res1..res6 into an internal buffer, sets idx=0, and moves to SEND.
REQ-017 Latency: a bundle accepted at edge k presents word 0 with out_valid=1 in the cycle after edge k.
REQ-018 In SEND: out_valid=1; out_data=buffer[idx] for idx 0..5; for idx 6, out_data=XOR of the six buffered words.
REQ-019 Final index is 6 when EMIT_CHECKSUM=1, otherwise 5; out_last=1 exactly at the final index.
REQ-020 A word transfers on out_valid&&out_ready; idx increments by 1 on each non-final transfer.
REQ-021 While out_valid&&!out_ready, out_data, out_idx and out_last stay stable.
REQ-022 In SEND, in_ready=1 only when out_last&&out_ready; otherwise in_ready=0. in_ready is combinational from out_ready in this cycle only.
REQ-023 Final transfer with a simultaneous input handshake: load the new bundle, set idx=0, remain in SEND with no idle bubble.
REQ-024 Final transfer without an input handshake: return to IDLE.
REQ-025 bundle_cnt increments on every final-word transfer and wraps from 0xFFFF to 0x0000.
REQ-026 All arithmetic is modulo 2^WIDTH; no sign interpretation.

Reset
REQ-027 While rst_n=0: state=IDLE, idx=0, buffer=0, bundle_cnt=0, out_valid=0, out_last=0, busy=0, in_ready=0, out_data=0, out_idx=0.
REQ-028 Reset asserted during SEND discards the partial bundle; after release, no remaining words of that bundle are emitted.
REQ-029 The first cycle after rst_n release is IDLE, with in_ready=1.

Structure
REQ-030 Shared package expr_pipe_pkg holds: the WIDTH default, N_RES=6, the CHK_IDX=6 constant, and the state enum type.
REQ-031 Single module; no sub-module. The checksum is an inline XOR reduction over the buffer.

Verification
REQ-032 Single bundle res=15,27,7,112,0xFFFFFFFD,30 with out_ready=1:
- words 15,27,7,112,0xFFFFFFFD,30,0xFFFFFF80 on idx 0..6;
- out_last only on idx 6;
- bundle_cnt becomes 1.
REQ-033 Same bundle with EMIT_CHECKSUM=0:
- six words emitted, out_last on idx 5;
- no idx 6 word.
REQ-034 out_ready held low 3 cycles at idx 2:
- out_data=7 and idx=2 held stable throughout;
- remaining sequence unchanged after the stall.
REQ-035 Back-to-back bundles with in_valid held high:
- second bundle's word 0 appears in the cycle immediately after the first bundle's final transfer;
- busy stays high across both bundles.
REQ-036 rst_n pulsed low during idx 3:
- all outputs go to reset values immediately;
- after release, in_ready=1 and no stale words are emitted.
REQ-037 Preload bundle_cnt near wrap, then emit bundles:
- preload by emitting 65535 bundles (or force in the bench);
- next bundle's final transfer wraps bundle_cnt to 0.

Source files
------------

// File: rtl/expr_pipe_pkg.sv
// Shared constants and types for the expression-result pipeline.
// The serializer imports these so bundle geometry is defined in one place.
package expr_pipe_pkg;

  localparam int         DEFAULT_WIDTH = 32;
  localparam int         N_RES         = 6;
  localparam logic [2:0] CHK_IDX       = 3'd6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/expr_result_serializer.sv
// Serializes a bundle of six expression results into a word stream.
// An optional XOR checksum word can be appended as the seventh word.
module expr_result_serializer
  import expr_pipe_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter bit EMIT_CHECKSUM = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] res1,
  input  logic [WIDTH-1:0] res2,
  input  logic [WIDTH-1:0] res3,
  input  logic [WIDTH-1:0] res4,
  input  logic [WIDTH-1:0] res5,
  input  logic [WIDTH-1:0] res6,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_idx,
  output logic             out_last,
  output logic             busy,
  output logic [15:0]      bundle_cnt
);

  localparam logic [2:0] LAST_IDX = EMIT_CHECKSUM ? CHK_IDX : 3'(N_RES - 1);

  state_t                      state;
  logic [N_RES-1:0][WIDTH-1:0] buffer;
  logic [2:0]                  idx;
  logic [2:0]                  next_idx;
  logic [WIDTH-1:0]            checksum;
  logic [WIDTH-1:0]            next_word;

  // XOR reduction over the buffered results.
  always_comb begin
    checksum = '0;
    for (int k = 0; k < N_RES; k++) begin
      checksum = checksum ^ buffer[k];
    end
  end

  // Word that will be presented after the current one transfers.
  always_comb begin
    next_idx = idx + 3'd1;
    case (next_idx)
      3'd0:    next_word = buffer[0];
      3'd1:    next_word = buffer[1];
      3'd2:    next_word = buffer[2];
      3'd3:    next_word = buffer[3];
      3'd4:    next_word = buffer[4];
      3'd5:    next_word = buffer[5];
      3'd6:    next_word = checksum;
      default: next_word = '0;
    endcase
  end

  // Accept only when idle, or when the final word leaves this very cycle.
  assign in_ready  = rst_n && ((state == IDLE) || (out_last && out_ready));
  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign out_idx   = idx;

  // Bundle capture, word sequencing and bundle accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      buffer     <= '0;
      idx        <= 3'd0;
      out_data   <= '0;
      out_last   <= 1'b0;
      bundle_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            buffer   <= {res6, res5, res4, res3, res2, res1};
            idx      <= 3'd0;
            out_data <= res1;
            out_last <= 1'b0;
            state    <= SEND;
          end else begin
            state <= IDLE;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              bundle_cnt <= bundle_cnt + 16'd1;
              idx        <= 3'd0;
              out_last   <= 1'b0;
              if (in_valid) begin
                // Reload straight away so the stream has no idle bubble.
                buffer   <= {res6, res5, res4, res3, res2, res1};
                out_data <= res1;
                state    <= SEND;
              end else begin
                out_data <= '0;
                state    <= IDLE;
              end
            end else begin
              idx      <= next_idx;
              out_data <= next_word;
              out_last <= (next_idx == LAST_IDX);
            end
          end else begin
            state <= SEND;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_expr_result_serializer.sv
// Directed bench for expr_result_serializer, with and without the checksum word.
module tb_expr_result_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [31:0] res1, res2, res3, res4, res5, res6;
  logic        in_ready, out_valid, out_last, busy;
  logic [31:0] out_data;
  logic [2:0]  out_idx;
  logic [15:0] bundle_cnt;

  logic        nc_in_valid, nc_out_ready;
  logic        nc_in_ready, nc_out_valid, nc_out_last, nc_busy;
  logic [31:0] nc_out_data;
  logic [2:0]  nc_out_idx;
  logic [15:0] nc_bundle_cnt;

  int n_cmp;
  int n_bad;
  logic [15:0] exp_cnt;

  logic [31:0] wa [7];
  logic [31:0] wb [7];

  expr_result_serializer #(.WIDTH(32), .EMIT_CHECKSUM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .res1(res1), .res2(res2), .res3(res3), .res4(res4), .res5(res5), .res6(res6),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .bundle_cnt(bundle_cnt)
  );

  expr_result_serializer #(.WIDTH(32), .EMIT_CHECKSUM(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .in_valid(nc_in_valid), .in_ready(nc_in_ready),
    .res1(res1), .res2(res2), .res3(res3), .res4(res4), .res5(res5), .res6(res6),
    .out_valid(nc_out_valid), .out_ready(nc_out_ready), .out_data(nc_out_data),
    .out_idx(nc_out_idx), .out_last(nc_out_last), .busy(nc_busy), .bundle_cnt(nc_bundle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_res(input logic [31:0] w [7]);
    res1 = w[0]; res2 = w[1]; res3 = w[2]; res4 = w[3]; res5 = w[4]; res6 = w[5];
  endtask

  // Pure driver: one bundle with out_ready high, returns once idle again.
  task automatic send_bundle(input logic [31:0] w [7]);
    set_res(w);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    nc_in_valid = 1'b0; nc_out_ready = 1'b0;
    res1 = 32'd0; res2 = 32'd0; res3 = 32'd0; res4 = 32'd0; res5 = 32'd0; res6 = 32'd0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_last, busy, in_ready} !== 4'b0000 || out_data !== 32'd0 ||
        out_idx !== 3'd0 || bundle_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b l=%b b=%b r=%b d=%h i=%0d c=%0d, need all zero",
               out_valid, out_last, busy, in_ready, out_data, out_idx, bundle_cnt);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, need 1/0", in_ready, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_single_bundle;
    set_res(wa);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_idx !== 3'(i) || out_data !== wa[i] || out_last !== (i == 6)) begin
        n_bad++;
        $display("FAIL single_word%0d: got v=%b idx=%0d data=%h last=%b, need v=1 idx=%0d data=%h last=%b",
                 i, out_valid, out_idx, out_data, out_last, i, wa[i], (i == 6));
      end
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++;
    if (out_valid !== 1'b0 || bundle_cnt !== exp_cnt || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_end: got v=%b cnt=%0d rdy=%b, need v=0 cnt=%0d rdy=1",
               out_valid, bundle_cnt, in_ready, exp_cnt);
    end
  endtask

  task automatic test_no_checksum;
    set_res(wa);
    nc_in_valid = 1'b1; nc_out_ready = 1'b1;
    @(negedge clk);
    nc_in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (nc_out_valid !== 1'b1 || nc_out_idx !== 3'(i) || nc_out_data !== wa[i] ||
          nc_out_last !== (i == 5)) begin
        n_bad++;
        $display("FAIL nochk_word%0d: got v=%b idx=%0d data=%h last=%b, need v=1 idx=%0d data=%h last=%b",
                 i, nc_out_valid, nc_out_idx, nc_out_data, nc_out_last, i, wa[i], (i == 5));
      end
      @(negedge clk);
    end
    n_cmp++;
    if (nc_out_valid !== 1'b0 || nc_bundle_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL nochk_end: got v=%b idx=%0d cnt=%0d, need v=0 cnt=1",
               nc_out_valid, nc_out_idx, nc_bundle_cnt);
    end
    nc_out_ready = 1'b0;
  endtask

  task automatic test_stall;
    set_res(wa);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (out_idx !== 3'(i) || out_data !== wa[i] || out_last !== (i == 6) || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_word%0d: got idx=%0d data=%h last=%b v=%b, need idx=%0d data=%h",
                 i, out_idx, out_data, out_last, out_valid, i, wa[i]);
      end
      if (i == 2) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          n_cmp++;
          if (out_idx !== 3'd2 || out_data !== 32'd7 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_hold%0d: got idx=%0d data=%h v=%b rdy=%b, need idx=2 data=7 v=1 rdy=0",
                     s, out_idx, out_data, out_valid, in_ready);
          end
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++;
    if (bundle_cnt !== exp_cnt || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_end: got cnt=%0d v=%b, need cnt=%0d v=0", bundle_cnt, out_valid, exp_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e;
    set_res(wa);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      e = (i < 7) ? wa[i] : wb[i-7];
      n_cmp++;
      if (busy !== 1'b1 || out_valid !== 1'b1 || out_idx !== 3'(i % 7) || out_data !== e) begin
        n_bad++;
        $display("FAIL b2b_word%0d: got busy=%b v=%b idx=%0d data=%h, need busy=1 v=1 idx=%0d data=%h",
                 i, busy, out_valid, out_idx, out_data, i % 7, e);
      end
      if (i == 6) begin
        set_res(wb);
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_ready: got in_ready=%b at final word, need 1", in_ready);
        end
      end
      if (i == 13) in_valid = 1'b0;
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 16'd2;
    n_cmp++;
    if (bundle_cnt !== exp_cnt || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end: got cnt=%0d v=%b busy=%b, need cnt=%0d v=0 busy=0",
               bundle_cnt, out_valid, busy, exp_cnt);
    end
  endtask

  task automatic test_reset_mid;
    set_res(wa);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_idx !== 3'd3 || out_data !== 32'd112) begin
      n_bad++;
      $display("FAIL rstmid_pre: got idx=%0d data=%h, need idx=3 data=70", out_idx, out_data);
    end
    rst_n = 1'b0;
    #1;
    exp_cnt = 16'd0;
    n_cmp++;
    if ({out_valid, out_last, busy, in_ready} !== 4'b0000 || out_data !== 32'd0 ||
        out_idx !== 3'd0 || bundle_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL rstmid_async: got v=%b l=%b b=%b r=%b d=%h i=%0d c=%0d, need all zero",
               out_valid, out_last, busy, in_ready, out_data, out_idx, bundle_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_ready: got in_ready=%b, need 1", in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL rstmid_stale%0d: got v=%b busy=%b idx=%0d, need v=0 busy=0", c, out_valid, busy, out_idx);
      end
    end
  endtask

  task automatic test_wrap;
    force dut.bundle_cnt = 16'hFFFE;
    #1;
    release dut.bundle_cnt;
    @(negedge clk);
    n_cmp++;
    if (bundle_cnt !== 16'hFFFE) begin
      n_bad++;
      $display("FAIL wrap_preload: got cnt=%h, need fffe", bundle_cnt);
    end
    send_bundle(wb);
    n_cmp++;
    if (bundle_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL wrap_ffff: got cnt=%h, need ffff", bundle_cnt);
    end
    send_bundle(wa);
    n_cmp++;
    if (bundle_cnt !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap_zero: got cnt=%h, need 0000", bundle_cnt);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_cnt = 16'd0;
    wa[0] = 32'd15; wa[1] = 32'd27; wa[2] = 32'd7; wa[3] = 32'd112;
    wa[4] = 32'hFFFF_FFFD; wa[5] = 32'd30; wa[6] = 32'hFFFF_FF80;
    wb[0] = 32'd1; wb[1] = 32'd2; wb[2] = 32'd3; wb[3] = 32'd4;
    wb[4] = 32'd5; wb[5] = 32'd6; wb[6] = 32'd7;
    test_reset();
    test_single_bundle();
    test_no_checksum();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
